// File: rtl/risc16_system.sv
// Single-cycle RiSC-16 system: program/data memories, 8x16 register file and PC.
// Program memory is written through pen/addr/instr while the core is held.

module risc16_regfile #(
    parameter int unsigned WORD_LENGTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             raddr_a_i,
    input  logic [2:0]             raddr_b_i,
    input  logic                   we_i,
    input  logic [2:0]             waddr_i,
    input  logic [WORD_LENGTH-1:0] wdata_i,
    output logic [WORD_LENGTH-1:0] rdata_a_o,
    output logic [WORD_LENGTH-1:0] rdata_b_o
);

    logic [WORD_LENGTH-1:0] dataRegister [0:7];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                dataRegister[i] <= '0;
            end
        end else if (we_i && (waddr_i != 3'd0)) begin
            dataRegister[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == 3'd0) ? '0 : dataRegister[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == 3'd0) ? '0 : dataRegister[raddr_b_i];

endmodule

module risc16_system #(
    parameter int unsigned WORD_LENGTH  = 16,
    parameter int unsigned PROGRAM_SIZE = 20,
    parameter int unsigned DATA_SIZE    = 20
) (
    input logic                   clk,
    input logic                   rst,
    input logic                   pen,
    input logic [WORD_LENGTH-1:0] addr,
    input logic [WORD_LENGTH-1:0] instr
);

    localparam int unsigned PAW = $clog2(PROGRAM_SIZE);
    localparam int unsigned DAW = $clog2(DATA_SIZE);

    localparam logic [2:0] OpAdd  = 3'b000;
    localparam logic [2:0] OpAddi = 3'b001;
    localparam logic [2:0] OpNand = 3'b010;
    localparam logic [2:0] OpLui  = 3'b011;
    localparam logic [2:0] OpSw   = 3'b100;
    localparam logic [2:0] OpLw   = 3'b101;
    localparam logic [2:0] OpBeq  = 3'b110;
    localparam logic [2:0] OpJalr = 3'b111;

    logic [WORD_LENGTH-1:0] imem [PROGRAM_SIZE];
    logic [WORD_LENGTH-1:0] dmem [DATA_SIZE];

    logic [WORD_LENGTH-1:0] pc_q, pc_d, pc_plus1;
    logic [WORD_LENGTH-1:0] PC, IR;
    logic [2:0]             op, ra, rb, rc, rd_b_addr;
    logic [WORD_LENGTH-1:0] simm, rb_val, rt_val, daddr, dmem_rdata;
    logic                   dmem_hit, run;
    logic                   rf_we, dmem_we;
    logic [WORD_LENGTH-1:0] rf_wdata;

    assign PC = pc_q;
    assign IR = (32'(pc_q) < PROGRAM_SIZE) ? imem[pc_q[PAW-1:0]] : '0;

    assign op   = IR[15:13];
    assign ra   = IR[12:10];
    assign rb   = IR[9:7];
    assign rc   = IR[2:0];
    assign simm = {{(WORD_LENGTH-7){IR[6]}}, IR[6:0]};

    // Second read port serves rC for add/nand and rA for sw/beq.
    assign rd_b_addr = ((op == OpAdd) || (op == OpNand)) ? rc : ra;

    risc16_regfile #(
        .WORD_LENGTH(WORD_LENGTH)
    ) rf (
        .clk      (clk),
        .rst      (rst),
        .raddr_a_i(rb),
        .raddr_b_i(rd_b_addr),
        .we_i     (rf_we),
        .waddr_i  (ra),
        .wdata_i  (rf_wdata),
        .rdata_a_o(rb_val),
        .rdata_b_o(rt_val)
    );

    assign daddr      = rb_val + simm;
    assign dmem_hit   = 32'(daddr) < DATA_SIZE;
    assign dmem_rdata = dmem_hit ? dmem[daddr[DAW-1:0]] : '0;
    assign pc_plus1   = pc_q + 1'b1;
    assign run        = !pen && rst;

    always_comb begin
        pc_d     = pc_plus1;
        rf_we    = 1'b0;
        rf_wdata = '0;
        dmem_we  = 1'b0;
        case (op)
            OpAdd:  begin rf_we = 1'b1; rf_wdata = rb_val + rt_val; end
            OpAddi: begin rf_we = 1'b1; rf_wdata = rb_val + simm; end
            OpNand: begin rf_we = 1'b1; rf_wdata = ~(rb_val & rt_val); end
            OpLui:  begin rf_we = 1'b1; rf_wdata = {IR[9:0], 6'b0}; end
            OpSw:   dmem_we = dmem_hit;
            OpLw:   begin rf_we = 1'b1; rf_wdata = dmem_rdata; end
            OpBeq:  if (rt_val == rb_val) pc_d = pc_plus1 + simm;
            OpJalr: begin rf_we = 1'b1; rf_wdata = pc_plus1; pc_d = rb_val; end
            default: ;
        endcase
        if (!run) begin
            pc_d    = pc_q;
            rf_we   = 1'b0;
            dmem_we = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Memories have no reset; programming ignores rst.
    always_ff @(posedge clk) begin
        if (pen && (32'(addr) < PROGRAM_SIZE)) begin
            imem[addr[PAW-1:0]] <= instr;
        end
    end

    always_ff @(posedge clk) begin
        if (dmem_we) begin
            dmem[daddr[DAW-1:0]] <= rt_val;
        end
    end

endmodule

// File: tb/tb_risc16_system.sv
// Bench for risc16_system: loads small programs, runs them and checks PC/IR/registers
// against expectations queued while the stimulus is built.

module tb_risc16_system;

    logic        clk;
    logic        rst;
    logic        pen;
    logic [15:0] addr;
    logic [15:0] instr;

    int total;
    int bad;

    typedef struct {
        string       tag;
        int          kind;  // 0 register, 1 PC, 2 IR
        int          idx;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];

    risc16_system dut (
        .clk  (clk),
        .rst  (rst),
        .pen  (pen),
        .addr (addr),
        .instr(instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rrr(logic [2:0] op, logic [2:0] a, logic [2:0] b,
                                        logic [2:0] c);
        return {op, a, b, 4'b0000, c};
    endfunction

    function automatic logic [15:0] ri(logic [2:0] op, logic [2:0] a, logic [2:0] b, int imm);
        logic [6:0] s;
        s = 7'(imm);
        return {op, a, b, s};
    endfunction

    function automatic logic [15:0] observe(int kind, int idx);
        if (kind == 1) return dut.PC;
        if (kind == 2) return dut.IR;
        return dut.rf.dataRegister[idx];
    endfunction

    task automatic check_eq(string tag, logic [15:0] got, logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic exp_reg(string tag, int idx, logic [15:0] v);
        sb.push_back('{tag, 0, idx, v});
    endtask

    task automatic exp_pc(string tag, logic [15:0] v);
        sb.push_back('{tag, 1, 0, v});
    endtask

    task automatic exp_ir(string tag, logic [15:0] v);
        sb.push_back('{tag, 2, 0, v});
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, observe(e.kind, e.idx), e.exp);
        end
    endtask

    // Called about 1 time unit after a rising edge; leaves pen=1 and an unused address.
    task automatic prog(int a, logic [15:0] w);
        pen   = 1'b1;
        addr  = 16'(a);
        instr = w;
        @(posedge clk);
        #1;
        addr  = 16'hFFFF;
    endtask

    task automatic run(int n);
        pen = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        pen = 1'b1;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        pen   = 1'b1;
        addr  = 16'hFFFF;
        instr = 16'h0000;
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) prog(i, 16'h0000);
        prog(25, 16'h1234);

        // lui/lui/add
        prog(0, 16'h6A00);
        prog(1, 16'h6D00);
        prog(2, 16'h0903);
        rst = 1'b0;
        #2;
        exp_pc("rst_pc", 16'h0000);
        exp_reg("rst_r2", 2, 16'h0000);
        exp_ir("rst_ir", 16'h6A00);
        drain();
        rst = 1'b1;
        #1;
        run(3);
        exp_reg("lui_add_r2", 2, 16'hC000);
        exp_reg("lui_r3", 3, 16'h4000);
        exp_pc("lui_add_pc", 16'd3);
        drain();

        // addi wrap and r0 write discard
        prog(0, 16'h247F);
        prog(1, ri(3'b001, 3'd1, 3'd1, 1));
        prog(2, ri(3'b001, 3'd0, 3'd0, 5));
        reset_pulse();
        run(1);
        exp_reg("addi_neg1", 1, 16'hFFFF);
        drain();
        run(1);
        exp_reg("addi_wrap", 1, 16'h0000);
        drain();
        run(1);
        exp_reg("r0_zero", 0, 16'h0000);
        exp_pc("addi_pc", 16'd3);
        drain();

        // sw/lw, including data addresses 19, 20 and 25
        prog(0, ri(3'b001, 3'd1, 3'd0, 7));
        prog(1, ri(3'b100, 3'd1, 3'd0, 3));
        prog(2, ri(3'b101, 3'd4, 3'd0, 3));
        prog(3, ri(3'b100, 3'd1, 3'd0, 19));
        prog(4, ri(3'b101, 3'd3, 3'd0, 19));
        prog(5, ri(3'b100, 3'd1, 3'd0, 20));
        prog(6, ri(3'b101, 3'd5, 3'd0, 20));
        prog(7, ri(3'b100, 3'd1, 3'd0, 25));
        prog(8, ri(3'b101, 3'd1, 3'd0, 25));
        reset_pulse();
        run(9);
        exp_reg("lw_3", 4, 16'd7);
        exp_reg("lw_19", 3, 16'd7);
        exp_reg("lw_20", 5, 16'd0);
        exp_reg("lw_25", 1, 16'd0);
        exp_pc("mem_pc", 16'd9);
        drain();

        // beq not taken, taken forward, self loop
        prog(0, ri(3'b001, 3'd1, 3'd0, 3));
        prog(1, ri(3'b110, 3'd1, 3'd0, 2));
        prog(2, ri(3'b001, 3'd2, 3'd0, 1));
        prog(3, ri(3'b110, 3'd2, 3'd2, 1));
        prog(4, ri(3'b001, 3'd4, 3'd0, 3));
        prog(5, ri(3'b110, 3'd0, 3'd0, -1));
        reset_pulse();
        run(5);
        exp_pc("beq_loop_pc", 16'd5);
        exp_reg("beq_nt_r2", 2, 16'd1);
        exp_reg("beq_skip_r4", 4, 16'd0);
        drain();
        run(3);
        exp_pc("beq_hold_pc", 16'd5);
        drain();

        // jalr, nand, running past the end of program memory
        prog(0, ri(3'b001, 3'd6, 3'd0, 10));
        prog(1, 16'h0000);
        prog(2, 16'h0000);
        prog(3, 16'h0000);
        prog(4, 16'hF700);
        prog(10, ri(3'b001, 3'd7, 3'd0, 9));
        prog(11, rrr(3'b010, 3'd3, 3'd7, 3'd7));
        prog(12, ri(3'b001, 3'd1, 3'd0, 20));
        prog(13, rrr(3'b111, 3'd1, 3'd1, 3'd0));
        reset_pulse();
        run(5);
        exp_reg("jalr_link", 5, 16'd5);
        exp_pc("jalr_pc", 16'd10);
        drain();
        run(2);
        exp_reg("nand_r3", 3, 16'hFFF6);
        exp_pc("nand_pc", 16'd12);
        drain();
        run(2);
        exp_reg("jalr_same_r1", 1, 16'd14);
        exp_pc("jalr_same_pc", 16'd20);
        exp_ir("past_end_ir", 16'h0000);
        drain();
        run(3);
        exp_pc("past_end_pc", 16'd23);
        exp_reg("past_end_r1", 1, 16'd14);
        exp_reg("past_end_r3", 3, 16'hFFF6);
        drain();

        // pen freeze, reprogram at PC, mid-run reset, rerun
        prog(0, ri(3'b001, 3'd1, 3'd0, 1));
        prog(1, ri(3'b001, 3'd2, 3'd0, 2));
        prog(2, ri(3'b001, 3'd3, 3'd0, 3));
        prog(3, rrr(3'b000, 3'd4, 3'd1, 3'd2));
        prog(4, ri(3'b110, 3'd0, 3'd0, -1));
        reset_pulse();
        run(2);
        idle(3);
        exp_pc("freeze_pc", 16'd2);
        exp_reg("freeze_r2", 2, 16'd2);
        exp_reg("freeze_r3", 3, 16'd0);
        drain();
        prog(2, ri(3'b001, 3'd3, 3'd0, 6));
        exp_ir("prog_at_pc_ir", ri(3'b001, 3'd3, 3'd0, 6));
        exp_pc("prog_at_pc_pc", 16'd2);
        drain();
        run(2);
        exp_reg("resume_r3", 3, 16'd6);
        exp_reg("resume_r4", 4, 16'd3);
        exp_pc("resume_pc", 16'd4);
        drain();
        rst = 1'b0;
        #1;
        exp_pc("midrst_pc", 16'd0);
        exp_reg("midrst_r1", 1, 16'd0);
        exp_reg("midrst_r4", 4, 16'd0);
        drain();
        prog(4, ri(3'b001, 3'd5, 3'd0, 5));
        prog(5, ri(3'b110, 3'd0, 3'd0, -1));
        exp_ir("midrst_ir", ri(3'b001, 3'd1, 3'd0, 1));
        drain();
        rst = 1'b1;
        #1;
        run(7);
        exp_pc("rerun_pc", 16'd5);
        exp_reg("rerun_r1", 1, 16'd1);
        exp_reg("rerun_r3", 3, 16'd6);
        exp_reg("rerun_r4", 4, 16'd3);
        exp_reg("rerun_r5", 5, 16'd5);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
